pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_entry.sv | 39 +++
 rtl/pipe_stage_buf.sv | 111 +++++++++++
 tb/tb_pipe_stage_buf.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: buffer occupancy encoding and the ID_EX payload layout,
// so decode and execute agree on where the control field sits.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  // ID_EX payload layout; the control field occupies the low bits
  localparam int ID_EX_W        = 32;
  localparam int ID_EX_CTRL_LSB = 0;
  localparam int ID_EX_CTRL_W   = 8;
  localparam int ID_EX_RD_LSB   = ID_EX_CTRL_LSB + ID_EX_CTRL_W;
  localparam int ID_EX_RD_W     = 5;
  localparam int ID_EX_IMM_LSB  = ID_EX_RD_LSB + ID_EX_RD_W;
  localparam int ID_EX_IMM_W    = ID_EX_W - ID_EX_IMM_LSB;

  function automatic logic [1:0] occ_of(occ_state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline storage entry: valid flag plus payload register.
// Invalidating an entry zeroes its control field so an empty slot always reads as a NOP.
module pipe_entry #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q              <= 1'b0;
      data_q[CTRL_W-1:0]   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (clr_i) begin
      valid_q              <= 1'b0;
      data_q[CTRL_W-1:0]   <= '0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// ID/EX pipeline stage buffer: valid/ready handshake on both sides, optional skid entry
// so s_ready is registered, and FLUSH that kills held entries and clears their control bits.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH  = ID_EX_W,
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occ
);

  occ_state_e       state_q, state_d;
  logic             s_fire, m_fire;
  logic             main_load, main_clr, skid_load, skid_clr;
  logic [WIDTH-1:0] main_din;
  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;

  assign s_fire = s_valid & s_ready & ~FLUSH;
  assign m_fire = main_valid & m_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_din  = s_data;
    case (state_q)
      ST_EMPTY: begin
        if (s_fire) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (s_fire && m_fire) begin
          main_load = 1'b1;
        end else if (m_fire) begin
          main_clr = 1'b1;
          state_d  = ST_EMPTY;
        end else if (s_fire && (SKID != 0)) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        // s_ready is low here, so only a drain can move the skid entry forward
        if (m_fire) begin
          main_load = 1'b1;
          main_din  = skid_data;
          skid_clr  = 1'b1;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (FLUSH) state_d = ST_EMPTY;
  end

  pipe_entry #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_main (
    .CLK     (CLK),
    .RST     (RST),
    .flush_i (FLUSH),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .data_i  (main_din),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_skid (
      .CLK     (CLK),
      .RST     (RST),
      .flush_i (FLUSH),
      .load_i  (skid_load),
      .clr_i   (skid_clr),
      .data_i  (s_data),
      .valid_o (skid_valid),
      .data_o  (skid_data)
    );
    assign s_ready = ~skid_valid;
  end else begin : g_noskid
    logic unused_skid;
    assign unused_skid = skid_load ^ skid_clr;
    assign skid_valid  = 1'b0;
    assign skid_data   = '0;
    assign s_ready     = ~main_valid | m_ready;
  end

  assign m_valid = main_valid;
  assign m_data  = main_data;
  assign occ     = occ_of(state_q);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid (SKID=1) and direct (SKID=0) instances driven side by side,
// with per-instance scoreboards that pair every accepted input with its output.
module tb_pipe_stage_buf;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;

  logic        flush1 = 0, s_valid1 = 0, m_ready1 = 0;
  logic [31:0] s_data1 = '0;
  logic        s_ready1, m_valid1;
  logic [31:0] m_data1;
  logic [1:0]  occ1;

  logic        flush0 = 0, s_valid0 = 0, m_ready0 = 0;
  logic [31:0] s_data0 = '0;
  logic        s_ready0, m_valid0;
  logic [31:0] m_data0;
  logic [1:0]  occ0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out0 = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic [31:0] exp1, exp0, hold_data1;
  logic        stall_prev1 = 1'b0;

  always #5 CLK = ~CLK;

  pipe_stage_buf #(.WIDTH(32), .CTRL_W(8), .SKID(1)) dut1 (
    .CLK(CLK), .RST(RST), .FLUSH(flush1),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .occ(occ1)
  );

  pipe_stage_buf #(.WIDTH(32), .CTRL_W(8), .SKID(0)) dut0 (
    .CLK(CLK), .RST(RST), .FLUSH(flush0),
    .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0), .occ(occ0)
  );

  // Inputs change 2 time units after each rising edge; the falling edge sees the
  // handshake that the next rising edge will complete.
  always @(negedge CLK) begin
    if (!RST) begin
      stall_prev1 = 1'b0;
    end else begin
      if (stall_prev1) begin
        n_cmp++;
        if (m_valid1 !== 1'b1 || m_data1 !== hold_data1) begin
          n_bad++;
          $display("FAIL stall_hold1: got v=%b d=%h want v=1 d=%h", m_valid1, m_data1, hold_data1);
        end
      end
      if (!m_valid1) begin
        n_cmp++;
        if (m_data1[7:0] !== 8'h00) begin
          n_bad++;
          $display("FAIL bubble_nop1: got ctrl=%h want 00", m_data1[7:0]);
        end
      end
      if (flush1) begin
        q1.delete();
      end else begin
        if (m_valid1 && m_ready1) begin
          n_cmp++;
          if (q1.size() == 0) begin
            n_bad++;
            $display("FAIL sb1_unexpected: got %h want nothing", m_data1);
          end else begin
            exp1 = q1.pop_front();
            if (m_data1 !== exp1) begin
              n_bad++;
              $display("FAIL sb1_data: got %h want %h", m_data1, exp1);
            end
          end
        end
        if (s_valid1 && s_ready1) q1.push_back(s_data1);
      end
      stall_prev1 = m_valid1 & ~m_ready1 & ~flush1;
      hold_data1  = m_data1;
    end
  end

  always @(negedge CLK) begin
    n_cmp++;
    if (s_ready0 !== (~m_valid0 | m_ready0) || occ0 > 2'd1) begin
      n_bad++;
      $display("FAIL ready0_rule: got rdy=%b occ=%0d want rdy=%b occ<=1",
               s_ready0, occ0, ~m_valid0 | m_ready0);
    end
    if (RST && !flush0) begin
      if (m_valid0 && m_ready0) begin
        n_cmp++;
        n_out0++;
        if (q0.size() == 0) begin
          n_bad++;
          $display("FAIL sb0_unexpected: got %h want nothing", m_data0);
        end else begin
          exp0 = q0.pop_front();
          if (m_data0 !== exp0) begin
            n_bad++;
            $display("FAIL sb0_data: got %h want %h", m_data0, exp0);
          end
        end
      end
      if (s_valid0 && s_ready0) q0.push_back(s_data0);
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    @(posedge CLK);
    #1;
    n_cmp++;
    if (occ1 !== 2'd0 || m_valid1 !== 1'b0 || m_data1 !== 32'h0 || s_ready1 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state1: got occ=%0d v=%b d=%h rdy=%b want 0 0 0 1",
               occ1, m_valid1, m_data1, s_ready1);
    end
    n_cmp++;
    if (occ0 !== 2'd0 || m_valid0 !== 1'b0 || s_ready0 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state0: got occ=%0d v=%b rdy=%b want 0 0 1", occ0, m_valid0, s_ready0);
    end
    #1;
    RST = 1'b1;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v[4];
    v[0] = 32'h11; v[1] = 32'h22; v[2] = 32'h33; v[3] = 32'h44;
    m_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid1 = 1'b1;
      s_data1  = v[i];
      @(posedge CLK);
      #1;
      n_cmp++;
      if (m_valid1 !== 1'b1 || m_data1 !== v[i] || s_ready1 !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_%0d: got v=%b d=%h rdy=%b want 1 %h 1", i, m_valid1, m_data1, s_ready1, v[i]);
      end
      #1;
    end
    s_valid1 = 1'b0;
    next_cycle();
    n_cmp++;
    if (m_valid1 !== 1'b0 || occ1 !== 2'd0) begin
      n_bad++;
      $display("FAIL b2b_drain: got v=%b occ=%0d want 0 0", m_valid1, occ1);
    end
  endtask

  task automatic test_skid_fill();
    m_ready1 = 1'b0;
    s_valid1 = 1'b1;
    s_data1  = 32'hA1;
    next_cycle();
    s_data1 = 32'hA2;
    next_cycle();
    n_cmp++;
    if (occ1 !== 2'd2 || s_ready1 !== 1'b0 || m_data1 !== 32'hA1) begin
      n_bad++;
      $display("FAIL skid_full: got occ=%0d rdy=%b d=%h want 2 0 a1", occ1, s_ready1, m_data1);
    end
    s_data1 = 32'hA3;
    next_cycle();
    n_cmp++;
    if (occ1 !== 2'd2 || m_data1 !== 32'hA1) begin
      n_bad++;
      $display("FAIL skid_a3_held_off: got occ=%0d d=%h want 2 a1", occ1, m_data1);
    end
    m_ready1 = 1'b1;
    next_cycle();
    n_cmp++;
    if (occ1 !== 2'd1 || m_data1 !== 32'hA2 || s_ready1 !== 1'b1) begin
      n_bad++;
      $display("FAIL skid_move: got occ=%0d d=%h rdy=%b want 1 a2 1", occ1, m_data1, s_ready1);
    end
    next_cycle();
    n_cmp++;
    if (occ1 !== 2'd1 || m_data1 !== 32'hA3) begin
      n_bad++;
      $display("FAIL skid_passthru: got occ=%0d d=%h want 1 a3", occ1, m_data1);
    end
    s_valid1 = 1'b0;
    next_cycle();
    n_cmp++;
    if (occ1 !== 2'd0 || m_valid1 !== 1'b0) begin
      n_bad++;
      $display("FAIL skid_empty: got occ=%0d v=%b want 0 0", occ1, m_valid1);
    end
  endtask

  task automatic test_flush();
    m_ready1 = 1'b0;
    s_valid1 = 1'b1;
    s_data1  = 32'hB1;
    next_cycle();
    s_data1 = 32'hB2;
    next_cycle();
    n_cmp++;
    if (occ1 !== 2'd2) begin
      n_bad++;
      $display("FAIL flush_pre: got occ=%0d want 2", occ1);
    end
    flush1   = 1'b1;
    s_valid1 = 1'b1;
    s_data1  = 32'hFF;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (m_valid1 !== 1'b0 || occ1 !== 2'd0 || m_data1[7:0] !== 8'h00 || s_ready1 !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_kill: got v=%b occ=%0d ctrl=%h rdy=%b want 0 0 00 1",
               m_valid1, occ1, m_data1[7:0], s_ready1);
    end
    #1;
    flush1   = 1'b0;
    s_valid1 = 1'b0;
    m_ready1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      n_cmp++;
      if (m_valid1 !== 1'b0 || m_data1 === 32'hFF) begin
        n_bad++;
        $display("FAIL flush_after_%0d: got v=%b d=%h want v=0", i, m_valid1, m_data1);
      end
    end
  endtask

  task automatic test_noskid_toggle();
    logic [31:0] nxt;
    logic        fire;
    nxt = 32'h100;
    for (int i = 0; i < 10; i++) begin
      m_ready0 = (i % 2 == 0);
      s_valid0 = 1'b1;
      s_data0  = nxt;
      #1;
      fire = s_ready0;
      @(posedge CLK);
      #2;
      if (fire) nxt = nxt + 32'h1;
    end
    s_valid0 = 1'b0;
    m_ready0 = 1'b1;
    next_cycle();
    next_cycle();
    n_cmp++;
    if (n_out0 !== int'(nxt - 32'h100) || q0.size() != 0) begin
      n_bad++;
      $display("FAIL noskid_count: got out=%0d left=%0d want out=%0d left=0",
               n_out0, q0.size(), nxt - 32'h100);
    end
  endtask

  task automatic test_reset_mid();
    m_ready1 = 1'b0;
    s_valid1 = 1'b1;
    s_data1  = 32'hC1;
    next_cycle();
    s_valid1 = 1'b0;
    n_cmp++;
    if (occ1 !== 2'd1) begin
      n_bad++;
      $display("FAIL rstmid_pre: got occ=%0d want 1", occ1);
    end
    #1;
    RST = 1'b0;
    q1.delete();
    q0.delete();
    #1;
    n_cmp++;
    if (m_valid1 !== 1'b0 || occ1 !== 2'd0 || m_data1 !== 32'h0 || s_ready1 !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_async: got v=%b occ=%0d d=%h rdy=%b want 0 0 0 1",
               m_valid1, occ1, m_data1, s_ready1);
    end
    next_cycle();
    RST = 1'b1;
    m_ready1 = 1'b1;
    s_valid1 = 1'b1;
    s_data1  = 32'hD1;
    @(posedge CLK);
    #1;
    n_cmp++;
    if (m_valid1 !== 1'b1 || m_data1 !== 32'hD1) begin
      n_bad++;
      $display("FAIL rstmid_first: got v=%b d=%h want 1 d1", m_valid1, m_data1);
    end
    #1;
    s_valid1 = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_final_drain();
    n_cmp++;
    if (q1.size() != 0 || q0.size() != 0) begin
      n_bad++;
      $display("FAIL final_drain: got left1=%0d left0=%0d want 0 0", q1.size(), q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_skid_fill();
    test_flush();
    test_noskid_toggle();
    test_reset_mid();
    test_final_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
